// File: rtl/operand_fetch.sv
// Register-read stage of the Beta core: drives the register file read ports,
// holds one instruction and resolves its operands by forwarding from EX/MEM/WB.
module operand_fetch #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5,
  parameter int IDX_ZR = 31
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              inValid_i,
  output logic              inReady_o,
  input  logic [31:0]       inInstr_i,
  input  logic [31:0]       inPc_i,
  output logic              rfEnX_o,
  output logic              rfEnY_o,
  output logic [W_ADDR-1:0] rfAddrX_o,
  output logic [W_ADDR-1:0] rfAddrY_o,
  input  logic [W_DATA-1:0] rfDataX_i,
  input  logic [W_DATA-1:0] rfDataY_i,
  input  logic              exValid_i,
  input  logic              memValid_i,
  input  logic              wbValid_i,
  input  logic [W_ADDR-1:0] exDest_i,
  input  logic [W_ADDR-1:0] memDest_i,
  input  logic [W_ADDR-1:0] wbDest_i,
  input  logic [W_DATA-1:0] exData_i,
  input  logic [W_DATA-1:0] memData_i,
  input  logic [W_DATA-1:0] wbData_i,
  input  logic              exIsLoad_i,
  output logic              outValid_o,
  input  logic              outReady_i,
  output logic [31:0]       outInstr_o,
  output logic [31:0]       outPc_o,
  output logic [W_DATA-1:0] outOpA_o,
  output logic [W_DATA-1:0] outOpB_o,
  output logic [W_DATA-1:0] outStoreData_o
);

  localparam logic [5:0]        OPC_ST = 6'h19;
  localparam logic [W_ADDR-1:0] ZR     = W_ADDR'(IDX_ZR);

  logic              rrValid_q, rrValid_d;
  logic [31:0]       irReg_q, irReg_d;
  logic [31:0]       pcReg_q, pcReg_d;
  logic [W_ADDR-1:0] heldAddrX, heldAddrY, inAddrX, inAddrY;
  logic              heldIsLit, heldUsesY, stall, accept;
  logic [W_DATA-1:0] opX, opY;

  function automatic logic [W_ADDR-1:0] portYAddr(input logic [31:0] instr);
    return (instr[31:26] == OPC_ST) ? W_ADDR'(instr[25:21]) : W_ADDR'(instr[15:11]);
  endfunction

  // Youngest producer wins; the zero register never takes a forwarded value.
  function automatic logic [W_DATA-1:0] forward(input logic [W_ADDR-1:0] addr,
                                                input logic [W_DATA-1:0] rfData);
    if (addr == ZR)                         return '0;
    else if (exValid_i  && exDest_i  == addr) return exData_i;
    else if (memValid_i && memDest_i == addr) return memData_i;
    else if (wbValid_i  && wbDest_i  == addr) return wbData_i;
    else                                    return rfData;
  endfunction

  assign heldAddrX = W_ADDR'(irReg_q[20:16]);
  assign heldAddrY = portYAddr(irReg_q);
  assign inAddrX   = W_ADDR'(inInstr_i[20:16]);
  assign inAddrY   = portYAddr(inInstr_i);

  // Opcode classes 01 and 11 carry a literal, which is exactly opcode bit 30.
  assign heldIsLit = irReg_q[30];
  assign heldUsesY = !heldIsLit || (irReg_q[31:26] == OPC_ST);

  assign stall = rrValid_q && exValid_i && exIsLoad_i && (exDest_i != ZR) &&
                 ((exDest_i == heldAddrX) || (heldUsesY && (exDest_i == heldAddrY)));

  assign inReady_o  = !flush_i && (!rrValid_q || (outReady_i && !stall));
  assign accept     = inValid_i && inReady_o;
  assign outValid_o = rrValid_q && !stall;

  // A held instruction re-reads every cycle so RF write-through stays visible.
  always_comb begin
    rfEnX_o   = 1'b0;
    rfEnY_o   = 1'b0;
    rfAddrX_o = '0;
    rfAddrY_o = '0;
    if (accept) begin
      rfEnX_o   = 1'b1;
      rfEnY_o   = 1'b1;
      rfAddrX_o = inAddrX;
      rfAddrY_o = inAddrY;
    end else if (rrValid_q) begin
      rfEnX_o   = 1'b1;
      rfEnY_o   = 1'b1;
      rfAddrX_o = heldAddrX;
      rfAddrY_o = heldAddrY;
    end
  end

  assign opX            = forward(heldAddrX, rfDataX_i);
  assign opY            = forward(heldAddrY, rfDataY_i);
  assign outOpA_o       = opX;
  assign outOpB_o       = heldIsLit ? {{(W_DATA-16){irReg_q[15]}}, irReg_q[15:0]} : opY;
  assign outStoreData_o = opY;
  assign outInstr_o     = irReg_q;
  assign outPc_o        = pcReg_q;

  always_comb begin
    rrValid_d = rrValid_q;
    irReg_d   = irReg_q;
    pcReg_d   = pcReg_q;
    if (flush_i) begin
      rrValid_d = 1'b0;
    end else if (accept) begin
      rrValid_d = 1'b1;
      irReg_d   = inInstr_i;
      pcReg_d   = inPc_i;
    end else if (outValid_o && outReady_i) begin
      rrValid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rrValid_q <= 1'b0;
      irReg_q   <= '0;
      pcReg_q   <= '0;
    end else begin
      rrValid_q <= rrValid_d;
      irReg_q   <= irReg_d;
      pcReg_q   <= pcReg_d;
    end
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read (RR) pipeline stage of the Beta core, sitting between instruction fetch and execute. It drives the register file's synchronous read ports, holds one instruction while the read completes, and resolves RAW hazards by forwarding from the EX, MEM and WB result buses. It stalls on load-use and presents a fully resolved operand bundle to EX through a valid/ready handshake.

## Interface
- W_DATA, 32, data and instruction width
- W_ADDR, 5, register address width
- IDX_ZR, 31, zero-register index: reads 0 and is never forwarded
- Clock  in  1  single clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- Flush  in  1  discard the held instruction and any incoming one this cycle
- InValid, InReady  in/out  1  fetch-side handshake
- InInstr, InPc  in  32  instruction word and its PC
- RfEnX, RfEnY  out  1  register-file read enables
- RfAddrX, RfAddrY  out  W_ADDR  register-file read addresses
- RfDataX, RfDataY  in  W_DATA  register-file read data, valid one cycle after the enabled read
- ExValid, MemValid, WbValid  in  1  producing instruction present in that stage
- ExDest, MemDest, WbDest  in  W_ADDR  destination register of that stage
- ExData, MemData, WbData  in  W_DATA  result of that stage
- ExIsLoad  in  1  EX instruction is a load; result not ready until MEM
- OutValid, OutReady  out/in  1  execute-side handshake
- OutInstr, OutPc  out  32  instruction and PC of the held instruction
- OutOpA, OutOpB, OutStoreData  out  W_DATA  resolved operands

## Operation
- Fields: opcode = Instr[31:26], Rc = [25:21], Ra = [20:16], Rb = [15:11], lit = [15:0]. The opcode constant ST is 6'h19.
- Port X address = Ra. Port Y address = Rc when opcode == ST, else Rb.
- State: RrValid, IrReg, PcReg.
- Accept happens when InValid && InReady. InReady = !Flush && (!RrValid || (OutReady && !Stall)).
- Read issue, combinational:
  - On accept, RfEn* = 1 with addresses from InInstr.
  - Else if RrValid, RfEn* = 1 with addresses from IrReg. This re-read refreshes the data every held cycle, and RF write-through covers a WB landing that cycle.
  - Else RfEn* = 0.
- Operand resolution for each of X and Y, using the IrReg addresses:
  - If the address is IDX_ZR, the operand is 0.
  - Else the first match wins: EX (ExValid && ExDest == addr) → ExData; MEM → MemData; WB → WbData; otherwise RfData.
  - Sources whose Dest == IDX_ZR never match.
- Stall = RrValid && ExValid && ExIsLoad && ExDest != IDX_ZR && (ExDest == addrX || ExDest == addrY_used).
  - addrY_used excludes literal-format instructions other than ST.
- OutOpA = operand X.
- OutOpB = sext(lit) when opcode[31:30] is 2'b11 or 2'b01; otherwise operand Y.
- OutStoreData = operand Y.
- OutValid = RrValid && !Stall. OutInstr and OutPc come from IrReg and PcReg.
- Register update, in priority order:
  - Reset or Flush: RrValid ← 0.
  - Else on accept: load IrReg and PcReg, RrValid ← 1.
  - Else on OutValid && OutReady: RrValid ← 0.
  - Else: hold.
- Reset values: RrValid = 0, IrReg = 0, PcReg = 0. Therefore OutValid = 0, InReady = 1 (when Flush is low), RfEn* = 0 (when InValid is low), and OutInstr = OutPc = 0.

## Timing
- Latency: an accept at edge n gives OutValid in the cycle after edge n, if there is no stall.
- Throughput: one instruction per cycle. A simultaneous drain and accept is allowed.
- Load-use: a one-cycle bubble. The next cycle the load is in MEM and is forwarded from MemData.
- Back-pressure: with OutReady low, all Out* signals are held stable and operands are re-resolved every cycle. The data value may change only if a forwarding source changes; the addresses never change.
- Flush with InValid: the instruction is not accepted (InReady = 0). The held instruction is dropped, and OutValid = 0 the next cycle.
- A Reset asserted mid-stall clears the stage at the next edge.

## Test plan
- **Back-to-back ALU ops.** ADD R1 ← R2+R3, then SUB R4 ← R1−R5, with EX showing Dest = 1 and Data = 0x10. Required: the second instruction's OutOpA = 0x10, and there is no bubble.
- **Load-use.** LD R7 in EX (ExIsLoad = 1), RR holding ADD using R7. Required: OutValid = 0 for one cycle. Next cycle MEM shows Dest = 7, Data = 0xCAFE, and OutOpA = 0xCAFE with OutValid = 1.
- **Zero register.** An instruction with Ra = 31 while EX has Dest = 31, Data = 0x55. Required: OutOpA = 0, and ST Rc = 31 gives OutStoreData = 0.
- **Long back-pressure.** OutReady low for 5 cycles while the producer of Ra passes EX→MEM→WB→retired, with RF now holding 0x1234. Required: OutOpA tracks the forwarded value each cycle and ends at 0x1234.
- **Flush.** Flush asserted with RrValid = 1 and InValid = 1. Required: InReady = 0 that cycle, OutValid = 0 next cycle, and the following InValid is accepted normally.
- **Reset mid-stall.** Required: outputs return to the reset values listed under Operation.
